// File: rtl/approx_mult_seq_ctrl.sv
// approx_mult_seq_ctrl
// ---------------------
// Time-multiplexed sequencer for the 8x8 approximate multiplier family.
// One 8x8 operation is split into four 4x4 quadrant products. The quadrants go
// through a single shared external 4x4 multiplier bank, one per cycle. The bank
// variant for each quadrant comes from a config word that is latched at accept.
// The partial products are combined into a 16-bit result. The middle terms are
// combined either by exact addition or by OR, depending on COMB_OR.
//
// Parameters
//   COMB_OR      1: middle terms combined as P1|P2, 0: exact sum P1+P2
//   CFG_DEFAULT  variant word used when cfg_use=0
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   in_valid/in_ready operand handshake (ready only in IDLE)
//   in_a, in_b        8-bit operands
//   cfg_use, cfg_var  variant word select / explicit variant word
//   mul_a, mul_b      nibble operands to the shared 4x4 bank
//   mul_var           variant select for the current quadrant
//   mul_r             bank result (combinational, captured the same cycle)
//   out_valid/out_ready result handshake, out_r is the 16-bit product
//   busy              high whenever the sequencer is not idle
//   op_cnt            completed result handshakes, wraps at 16 bits

module approx_mult_seq_ctrl #(
  parameter bit         COMB_OR     = 1'b1,
  parameter logic [7:0] CFG_DEFAULT = 8'hDA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  input  logic        cfg_use,
  input  logic [7:0]  cfg_var,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  output logic [1:0]  mul_var,
  input  logic [7:0]  mul_r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_r,
  output logic        busy,
  output logic [15:0] op_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  qcnt;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [7:0]  cfg_q;
  logic [15:0] acc;
  logic [8:0]  mid;
  logic        accept;
  logic        take;

  assign accept = (state == IDLE) && in_valid;
  assign take   = (state == DONE) && out_ready;

  // Next-state logic: one IDLE cycle to accept, four MUL cycles (one per
  // quadrant), then DONE until the consumer takes the result.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)      state_nxt = MUL;
      MUL:     if (qcnt == 2'd3)  state_nxt = DONE;
      DONE:    if (out_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // State register. Reset from any state drops the in-flight op.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand latch and quadrant accumulation. acc collects P0 first and then
  // the P3 and middle terms on the last quadrant. mid holds P1 until P2
  // arrives, so the OR or exact combine only touches the middle term. The
  // 9-bit mid keeps the carry of P1+P2, and every add is done at full 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      qcnt  <= 2'd0;
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      cfg_q <= 8'h00;
      acc   <= 16'h0000;
      mid   <= 9'h000;
    end else if (accept) begin
      qcnt  <= 2'd0;
      a_q   <= in_a;
      b_q   <= in_b;
      cfg_q <= cfg_use ? cfg_var : CFG_DEFAULT;
      acc   <= 16'h0000;
      mid   <= 9'h000;
    end else if (state == MUL) begin
      qcnt <= qcnt + 2'd1;
      case (qcnt)
        2'd0: acc <= {8'h00, mul_r};
        2'd1: mid <= {1'b0, mul_r};
        2'd2: begin
          if (COMB_OR) mid <= {1'b0, mid[7:0] | mul_r};
          else         mid <= mid + {1'b0, mul_r};
        end
        2'd3: acc <= acc + {mul_r, 8'h00} + {3'b000, mid, 4'h0};
        default: acc <= acc;
      endcase
    end
  end

  // Completed-operation counter, stepped only on a result handshake.
  always_ff @(posedge clk) begin
    if (rst)       op_cnt <= 16'h0000;
    else if (take) op_cnt <= op_cnt + 16'h0001;
  end

  // Bank drive. Quadrant q uses A's high nibble when q[1] is set and B's high
  // nibble when q[0] is set. The bus is forced to zero outside MUL so the bank
  // sees a quiet, deterministic input while it is not in use.
  always_comb begin
    mul_a   = 4'h0;
    mul_b   = 4'h0;
    mul_var = 2'd0;
    if (state == MUL) begin
      mul_a = qcnt[1] ? a_q[7:4] : a_q[3:0];
      mul_b = qcnt[0] ? b_q[7:4] : b_q[3:0];
      case (qcnt)
        2'd0:    mul_var = cfg_q[1:0];
        2'd1:    mul_var = cfg_q[3:2];
        2'd2:    mul_var = cfg_q[5:4];
        default: mul_var = cfg_q[7:6];
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign out_r     = acc;

endmodule
